uart_imem_loader: RTL and testbench
===================================

# uart_imem_loader

Serial program loader feeding the instruction-memory write path ahead of the fetch stage. While `prog` is high it receives a length-prefixed byte stream on `rx` (8N1, LSB first), assembles little-endian 32-bit words and issues one write strobe per word with a sequential word address starting at 0. It drives `memcon_prog_ena` and `uart_dout`, the two signals the fetch stage and imem controller consume. It also reports done and error status for the debug display.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer division, must be ≥ 4.
- `IMEM_AW`, default 12: word-address width; depth = 2**IMEM_AW.
- `clk` in 1: system clock. One clock only.
- `Rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous UART line, idle high.
- `prog` in 1: programming mode enable, level.
- `uart_dout` out 32: assembled word; valid when `uart_we` is high.
- `uart_addr` out IMEM_AW: word address of `uart_dout`.
- `uart_we` out 1: one-cycle write strobe.
- `memcon_prog_ena` out 1: high while a frame is in progress, from the first length byte through the final write or check.
- `load_done` out 1: sticky; frame completed without error.
- `load_err` out 1: sticky; framing, overflow or checksum error.

## Operation
- `rx` is passed through a 2-flop synchronizer. Start is detected on a falling edge and confirmed low at half-bit. Each bit is then sampled every `CLKS_PER_BIT` clocks at mid-bit.
- A stop bit sampled low causes a framing error: the byte is discarded, `load_err` is set, and the loader returns to WAIT_LEN_LO.
- Frame format: N_lo, N_hi (16-bit word count N), then 4N payload bytes, with byte 0 as the word LSB.
- Loader FSM states:
  - IDLE: exit on a rising edge of `prog`. On that edge, clear `load_done`, `load_err`, the address counter and the byte index.
  - WAIT_LEN_LO.
  - WAIT_LEN_HI: if N = 0, go to FINISH; otherwise go to DATA.
  - DATA: the 4th byte of each word produces `uart_we`, then the address increments. After word N, go to CHK when the checksum feature is compiled in, else FINISH.
  - CHK.
  - FINISH: set `load_done` unless `load_err` is set, then go to IDLE.
- `prog` falling in any state forces IDLE on the next cycle. Partial words are dropped, no strobe is issued, and the sticky flags are held.
- Overflow: if N > 2**IMEM_AW, set `load_err` in WAIT_LEN_HI. Bytes are still consumed, and strobes are suppressed for word indices ≥ 2**IMEM_AW. The address never wraps.
- Bytes received while in IDLE are ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, receiver idle.
- The receiver's internal byte-valid pulse is one cycle wide, occurring the cycle after the stop-bit sample.
- `uart_we` is asserted the cycle after the 4th byte's byte-valid. `uart_dout` and `uart_addr` are stable for that cycle, and the address increments on the following edge.
- `memcon_prog_ena` rises the cycle the FSM leaves IDLE and falls the cycle FINISH is entered.
- `load_done` rises on entry to FINISH.
- `Rst` mid-frame: all state cleared on that edge, no strobe issued.
- The `prog` rising edge and a byte-valid in the same cycle: the byte is ignored.

## Configuration
- `UART_LOADER_CHKSUM_EN` defined: after the payload, one extra byte is received. It must equal the XOR of all 4N payload bytes, or 0x00 when N = 0. On mismatch, `load_err` is set and `load_done` stays 0. Writes have already been issued and are not undone.
- Undefined: no CHK state, and the frame ends after the last payload byte.

## Structure
- The package `uart_loader_pkg` holds the FSM state enum `loader_state_t` and the localparams `CLKS_PER_BIT` and `HALF_BIT`.
- Sub-module `uart_rx_byte` contains the synchronizer, the bit timer and the shift register. It outputs `byte_data[7:0]`, `byte_valid` and `frame_err`.
- The top level holds the FSM, byte index, word assembler, address counter and checksum.

## Test plan
All scenarios use `CLK_FREQ=1_000_000`, `BAUD=100_000` (10 clocks/bit) and `IMEM_AW=4`.
- Single word: `prog`=1, then send 01 00 EF BE AD DE. Expect exactly one `uart_we` with `uart_addr`=0 and `uart_dout`=0xDEADBEEF, then `load_done`=1 and `load_err`=0.
- Three words: N=3, payload 0x00000013, 0x00100093, 0x00208113. Expect strobes at addresses 0, 1 and 2 with those values. `memcon_prog_ena` is high from the first bit through the last strobe.
- Overflow: N=17. Expect `load_err`=1, 16 strobes (addresses 0–15), no 17th strobe, and `load_done`=0.
- Framing error: 2nd payload byte sent with stop bit 0. Expect `load_err`=1, no strobe, and the FSM back in WAIT_LEN_LO.
- Abort: drop `prog` after 2 payload bytes. Expect no strobe, `memcon_prog_ena`=0 the next cycle, and a re-raised `prog` restarting at address 0.
- Checksum (`UART_LOADER_CHKSUM_EN`): payload EF BE AD DE.
  - Checksum byte 0x22: expect `load_done`=1.
  - Checksum byte 0x23: expect `load_err`=1 and the write at address 0 still present.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and bit-timing defaults for the UART imem loader.
// CHK state only exists when UART_LOADER_CHKSUM_EN is defined.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LEN_LO,
      WAIT_LEN_HI,
      DATA,
`ifdef UART_LOADER_CHKSUM_EN
      CHK,
`endif
      FINISH
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int unsigned CLK_FREQ_DEF = 100_000_000;
   localparam int unsigned BAUD_DEF     = 115_200;
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ_DEF / BAUD_DEF;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;

   function automatic int unsigned clks_per_bit(
      input int unsigned f,
      input int unsigned b
   );
      return f / b;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, half-bit start check,
// mid-bit sampling, one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
   import uart_loader_pkg::*;
#(
   parameter int unsigned CPB = CLKS_PER_BIT
)(
   input  logic       clk,
   input  logic       Rst,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned TW = $clog2(CPB) + 1;
   localparam logic [TW-1:0] T_FULL = TW'(CPB - 1);
   localparam logic [TW-1:0] T_HALF = TW'(CPB / 2 - 1);

   logic rx_s1, rx_s2, rx_d;
   rx_state_t st, st_n;
   logic [TW-1:0] tmr, tmr_n;
   logic [2:0] bcnt, bcnt_n;
   logic [7:0] sh, sh_n;
   logic vld_n, ferr_n;

   assign byte_data = sh;

   always_ff @(posedge clk) begin
      if (Rst) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_d       <= 1'b1;
         st         <= RX_IDLE;
         tmr        <= '0;
         bcnt       <= '0;
         sh         <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_s1      <= rx;
         rx_s2      <= rx_s1;
         rx_d       <= rx_s2;
         st         <= st_n;
         tmr        <= tmr_n;
         bcnt       <= bcnt_n;
         sh         <= sh_n;
         byte_valid <= vld_n;
         frame_err  <= ferr_n;
      end
   end

   always_comb begin
      st_n   = st;
      tmr_n  = tmr;
      bcnt_n = bcnt;
      sh_n   = sh;
      vld_n  = 1'b0;
      ferr_n = 1'b0;
      unique case (st)
         RX_IDLE: begin
            if (rx_d && !rx_s2) begin
               st_n  = RX_START;
               tmr_n = T_HALF;
            end
         end
         RX_START: begin
            if (tmr == '0) begin
               // a glitch that is gone by mid-bit is not a start bit
               if (!rx_s2) begin
                  st_n   = RX_DATA;
                  tmr_n  = T_FULL;
                  bcnt_n = '0;
               end else begin
                  st_n = RX_IDLE;
               end
            end else begin
               tmr_n = tmr - 1'b1;
            end
         end
         RX_DATA: begin
            if (tmr == '0) begin
               sh_n   = {rx_s2, sh[7:1]};
               tmr_n  = T_FULL;
               bcnt_n = bcnt + 3'd1;
               if (bcnt == 3'd7) st_n = RX_STOP;
            end else begin
               tmr_n = tmr - 1'b1;
            end
         end
         RX_STOP: begin
            if (tmr == '0) begin
               vld_n  = rx_s2;
               ferr_n = !rx_s2;
               st_n   = RX_IDLE;
            end else begin
               tmr_n = tmr - 1'b1;
            end
         end
         default: st_n = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_imem_loader.sv
// Serial program loader: length-prefixed byte stream to imem writes.
// Define UART_LOADER_CHKSUM_EN for the trailing XOR checksum byte.
module uart_imem_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 115_200,
   parameter int unsigned IMEM_AW  = 12
)(
   input  logic               clk,
   input  logic               Rst,
   input  logic               rx,
   input  logic               prog,
   output logic [31:0]        uart_dout,
   output logic [IMEM_AW-1:0] uart_addr,
   output logic               uart_we,
   output logic               memcon_prog_ena,
   output logic               load_done,
   output logic               load_err
);

   localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
   localparam logic [16:0] DEPTH = 17'd1 << IMEM_AW;

   loader_state_t state, state_n;
   logic [7:0]  bdata;
   logic        bvalid, ferr;
   logic        prog_d, prog_rise;
   logic [7:0]  len_lo;
   logic [15:0] nwords, n_hi;
   logic [1:0]  bidx;
   logic [16:0] wcnt;
   logic [31:0] word;
   logic [7:0]  chk;
   logic        word_done, last_q, wlast;
   logic        clr, restart, set_err, set_done;
   logic        take_lo, take_hi, take_dat;

   uart_rx_byte #(
      .CPB (CPB)
   ) u_rx (
      .clk        (clk),
      .Rst        (Rst),
      .rx         (rx),
      .byte_data  (bdata),
      .byte_valid (bvalid),
      .frame_err  (ferr)
   );

   assign prog_rise = prog && !prog_d;
   assign n_hi      = {bdata, len_lo};
   assign wlast     = (wcnt + 17'd1) == {1'b0, nwords};
   assign memcon_prog_ena = (state != IDLE) && (state != FINISH);

   always_ff @(posedge clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      clr      = 1'b0;
      restart  = 1'b0;
      set_err  = 1'b0;
      take_lo  = 1'b0;
      take_hi  = 1'b0;
      take_dat = 1'b0;
      if (!prog) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (prog_rise) begin
                  state_n = WAIT_LEN_LO;
                  clr     = 1'b1;
               end
            end
            WAIT_LEN_LO: begin
               if (ferr) begin
                  set_err = 1'b1;
                  restart = 1'b1;
               end else if (bvalid) begin
                  take_lo = 1'b1;
                  state_n = WAIT_LEN_HI;
               end
            end
            WAIT_LEN_HI: begin
               if (ferr) begin
                  set_err = 1'b1;
                  restart = 1'b1;
                  state_n = WAIT_LEN_LO;
               end else if (bvalid) begin
                  take_hi = 1'b1;
                  if ({1'b0, n_hi} > DEPTH) set_err = 1'b1;
                  if (n_hi != 16'd0) state_n = DATA;
`ifdef UART_LOADER_CHKSUM_EN
                  else state_n = CHK;
`else
                  else state_n = FINISH;
`endif
               end
            end
            DATA: begin
               // leave only after the last strobe has been issued
               if (word_done && last_q) begin
`ifdef UART_LOADER_CHKSUM_EN
                  state_n = CHK;
`else
                  state_n = FINISH;
`endif
               end else if (ferr) begin
                  set_err = 1'b1;
                  restart = 1'b1;
                  state_n = WAIT_LEN_LO;
               end else if (bvalid) begin
                  take_dat = 1'b1;
               end
            end
`ifdef UART_LOADER_CHKSUM_EN
            CHK: begin
               if (ferr) begin
                  set_err = 1'b1;
                  restart = 1'b1;
                  state_n = WAIT_LEN_LO;
               end else if (bvalid) begin
                  if (bdata != chk) set_err = 1'b1;
                  state_n = FINISH;
               end
            end
`endif
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
      set_done = (state_n == FINISH) && (state != FINISH)
               && !load_err && !set_err;
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         prog_d    <= 1'b0;
         uart_dout <= '0;
         uart_addr <= '0;
         uart_we   <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         len_lo    <= '0;
         nwords    <= '0;
         bidx      <= '0;
         wcnt      <= '0;
         word      <= '0;
         chk       <= '0;
         word_done <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         prog_d    <= prog;
         uart_we   <= 1'b0;
         word_done <= 1'b0;
         if (uart_we && (uart_addr != '1))
            uart_addr <= uart_addr + IMEM_AW'(1);
         if (clr) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            last_q    <= 1'b0;
         end
         if (clr || restart) begin
            uart_addr <= '0;
            bidx      <= '0;
            wcnt      <= '0;
            chk       <= '0;
         end
         if (set_err)  load_err  <= 1'b1;
         if (set_done) load_done <= 1'b1;
         if (take_lo)  len_lo    <= bdata;
         if (take_hi)  nwords    <= n_hi;
         if (take_dat) begin
            word <= {bdata, word[31:8]};
            chk  <= chk ^ bdata;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
               word_done <= 1'b1;
               uart_we   <= (wcnt < DEPTH);
               uart_dout <= {bdata, word[31:8]};
               last_q    <= wlast;
               wcnt      <= wcnt + 17'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader with a write scoreboard.
// Checksum scenarios run only when UART_LOADER_CHKSUM_EN is defined.
module tb_uart_imem_loader;
   import uart_loader_pkg::*;

   logic        clk;
   logic        Rst;
   logic        rx;
   logic        prog;
   logic [31:0] uart_dout;
   logic [3:0]  uart_addr;
   logic        uart_we;
   logic        memcon_prog_ena;
   logic        load_done;
   logic        load_err;

   int checks = 0;
   int errors = 0;
   int n_we   = 0;
   int we_ref = 0;
   logic [35:0] exp_q[$];
   logic [35:0] mon_e;
   logic [31:0] pay [0:31];

   uart_imem_loader #(
      .CLK_FREQ (1_000_000),
      .BAUD     (100_000),
      .IMEM_AW  (4)
   ) dut (
      .clk             (clk),
      .Rst             (Rst),
      .rx              (rx),
      .prog            (prog),
      .uart_dout       (uart_dout),
      .uart_addr       (uart_addr),
      .uart_we         (uart_we),
      .memcon_prog_ena (memcon_prog_ena),
      .load_done       (load_done),
      .load_err        (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [35:0] obs,
                      input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      rx = 1'b0;
      tick(10);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(10);
      end
      rx = stop;
      tick(10);
      rx = 1'b1;
      tick(stop ? 2 : 12);
   endtask

   task automatic send_frame(input int n, input bit bad);
      logic [7:0] x;
      logic [15:0] nn;
      logic [31:0] w;
      x  = 8'h00;
      nn = n[15:0];
      send_byte(nn[7:0], 1'b1);
      send_byte(nn[15:8], 1'b1);
      for (int i = 0; i < n; i++) begin
         w = pay[i];
         if (i < 16) exp_q.push_back({i[3:0], w});
         for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
            x = x ^ w[8*k +: 8];
         end
      end
`ifdef UART_LOADER_CHKSUM_EN
      send_byte(x ^ {7'd0, bad}, 1'b1);
`else
      x = x ^ {7'd0, bad};
`endif
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 400 && memcon_prog_ena; k++) tick(1);
      chk(tag, 36'(memcon_prog_ena), 36'(0));
   endtask

   task automatic reprog();
      prog = 1'b0;
      tick(3);
      prog = 1'b1;
      tick(2);
   endtask

   always @(negedge clk) begin
      if (uart_we) begin
         n_we++;
         chk("we_expected", 36'(exp_q.size() != 0), 36'(1));
         chk("we_ena", 36'(memcon_prog_ena), 36'(1));
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("we_addr", 36'(uart_addr), 36'(mon_e[35:32]));
            chk("we_data", 36'(uart_dout), 36'(mon_e[31:0]));
         end
      end
   end

   initial begin
      Rst  = 1'b1;
      rx   = 1'b1;
      prog = 1'b0;
      tick(3);
      chk("rst_we",   36'(uart_we), 36'(0));
      chk("rst_ena",  36'(memcon_prog_ena), 36'(0));
      chk("rst_done", 36'(load_done), 36'(0));
      chk("rst_err",  36'(load_err), 36'(0));
      chk("rst_addr", 36'(uart_addr), 36'(0));
      chk("rst_dout", 36'(uart_dout), 36'(0));
      Rst = 1'b0;
      tick(2);

      // single word
      prog = 1'b1;
      tick(2);
      chk("ena_rise", 36'(memcon_prog_ena), 36'(1));
      pay[0] = 32'hDEADBEEF;
      we_ref = n_we;
      send_frame(1, 1'b0);
      wait_idle("one_idle");
      chk("one_cnt",  36'(n_we - we_ref), 36'(1));
      chk("one_done", 36'(load_done), 36'(1));
      chk("one_err",  36'(load_err), 36'(0));

      // three words
      reprog();
      chk("three_clr", 36'(load_done), 36'(0));
      pay[0] = 32'h00000013;
      pay[1] = 32'h00100093;
      pay[2] = 32'h00208113;
      we_ref = n_we;
      send_frame(3, 1'b0);
      wait_idle("three_idle");
      chk("three_cnt",  36'(n_we - we_ref), 36'(3));
      chk("three_done", 36'(load_done), 36'(1));
      chk("three_err",  36'(load_err), 36'(0));

      // overflow: 17 words into a 16-word memory
      reprog();
      for (int i = 0; i < 17; i++)
         pay[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      we_ref = n_we;
      send_frame(17, 1'b0);
      wait_idle("ovf_idle");
      chk("ovf_cnt",  36'(n_we - we_ref), 36'(16));
      chk("ovf_err",  36'(load_err), 36'(1));
      chk("ovf_done", 36'(load_done), 36'(0));
      chk("ovf_addr", 36'(uart_addr), 36'(15));

      // framing error on 2nd payload byte
      reprog();
      we_ref = n_we;
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hEF, 1'b1);
      send_byte(8'hBE, 1'b0);
      tick(5);
      chk("fe_err",   36'(load_err), 36'(1));
      chk("fe_cnt",   36'(n_we - we_ref), 36'(0));
      chk("fe_state", 36'(dut.state), 36'(WAIT_LEN_LO));
      chk("fe_ena",   36'(memcon_prog_ena), 36'(1));

      // abort after two payload bytes
      reprog();
      chk("ab_clr", 36'(load_err), 36'(0));
      we_ref = n_we;
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hEF, 1'b1);
      send_byte(8'hBE, 1'b1);
      prog = 1'b0;
      tick(1);
      chk("ab_ena", 36'(memcon_prog_ena), 36'(0));
      tick(5);
      chk("ab_cnt", 36'(n_we - we_ref), 36'(0));
      prog = 1'b1;
      tick(2);
      pay[0] = 32'h01234567;
      send_frame(1, 1'b0);
      wait_idle("ab_idle");
      chk("ab_recnt", 36'(n_we - we_ref), 36'(1));
      chk("ab_done",  36'(load_done), 36'(1));

`ifdef UART_LOADER_CHKSUM_EN
      reprog();
      pay[0] = 32'hDEADBEEF;
      send_frame(1, 1'b0);
      wait_idle("ck_ok_idle");
      chk("ck_ok_done", 36'(load_done), 36'(1));
      chk("ck_ok_err",  36'(load_err), 36'(0));
      reprog();
      we_ref = n_we;
      send_frame(1, 1'b1);
      wait_idle("ck_bad_idle");
      chk("ck_bad_cnt",  36'(n_we - we_ref), 36'(1));
      chk("ck_bad_err",  36'(load_err), 36'(1));
      chk("ck_bad_done", 36'(load_done), 36'(0));
`endif

      // reset in the middle of a word
      reprog();
      we_ref = n_we;
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hEF, 1'b1);
      send_byte(8'hBE, 1'b1);
      send_byte(8'hAD, 1'b1);
      Rst = 1'b1;
      tick(1);
      chk("mr_ena",  36'(memcon_prog_ena), 36'(0));
      chk("mr_addr", 36'(uart_addr), 36'(0));
      chk("mr_done", 36'(load_done), 36'(0));
      Rst  = 1'b0;
      prog = 1'b0;
      tick(20);
      chk("mr_cnt", 36'(n_we - we_ref), 36'(0));
      chk("q_empty", 36'(exp_q.size()), 36'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
